// File: rtl/output_display.sv
// SAP-1 output register with sequential binary-to-BCD conversion (shift-add-3)
// and a free-running, multiplexed 3-digit 7-segment driver with leading-zero blanking.
`timescale 1ns/1ps
module output_display #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned SCAN_DIV = 16
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             LO,
  output logic [WIDTH-1:0] out_reg,
  output logic             busy,
  output logic [2:0]       digit_sel,
  output logic [6:0]       seg
);

  localparam int unsigned BcdW = 12;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DivW = 16;

  typedef enum logic [0:0] {StIdle, StConvert} state_e;

  state_e              r_state, w_state_next;
  logic [WIDTH-1:0]    r_out;
  logic [WIDTH-1:0]    r_shift;
  logic [BcdW-1:0]     r_scratch;
  logic [CntW-1:0]     r_count;
  logic [3:0]          r_hund, r_tens, r_ones;
  logic [DivW-1:0]     r_div;
  logic [2:0]          r_digit_sel;

  logic [BcdW-1:0]       w_adj;
  logic [BcdW+WIDTH-1:0] w_shifted;
  logic                  w_last;
  logic [3:0]            w_nib;
  logic                  w_blank;

  // Add-3 correction on every BCD nibble, then one left shift of {scratch, shift}.
  always_comb begin
    w_adj = '0;
    for (int i = 0; i < 3; i++) begin
      w_adj[4*i+:4] = (r_scratch[4*i+:4] >= 4'd5) ? r_scratch[4*i+:4] + 4'd3
                                                   : r_scratch[4*i+:4];
    end
    w_shifted = {w_adj, r_shift} << 1;
    w_last    = (r_count == CntW'(WIDTH - 1));
  end

  always_comb begin
    w_state_next = r_state;
    if (!LO) begin
      w_state_next = StConvert;
    end else begin
      case (r_state)
        StIdle:    w_state_next = StIdle;
        StConvert: if (w_last) w_state_next = StIdle;
        default:   w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A load wins over the conversion step on the same edge.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_out     <= '0;
      r_shift   <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_hund    <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
    end else if (!LO) begin
      r_out     <= bus_in;
      r_shift   <= bus_in;
      r_scratch <= '0;
      r_count   <= '0;
    end else if (r_state == StConvert) begin
      r_scratch <= w_shifted[WIDTH+:BcdW];
      r_shift   <= w_shifted[WIDTH-1:0];
      r_count   <= r_count + CntW'(1);
      if (w_last) begin
        r_ones <= w_shifted[WIDTH+:4];
        r_tens <= w_shifted[WIDTH+4+:4];
        r_hund <= w_shifted[WIDTH+8+:4];
      end
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      r_div       <= '0;
      r_digit_sel <= 3'b001;
    end else if (r_div == DivW'(SCAN_DIV - 1)) begin
      r_div       <= '0;
      r_digit_sel <= {r_digit_sel[1:0], r_digit_sel[2]};
    end else begin
      r_div <= r_div + DivW'(1);
    end
  end

  always_comb begin
    w_nib   = '0;
    w_blank = 1'b1;
    unique case (r_digit_sel)
      3'b001: begin
        w_nib   = r_ones;
        w_blank = 1'b0;
      end
      3'b010: begin
        w_nib   = r_tens;
        w_blank = (r_hund == 4'd0) && (r_tens == 4'd0);
      end
      3'b100: begin
        w_nib   = r_hund;
        w_blank = (r_hund == 4'd0);
      end
      default: begin
        w_nib   = '0;
        w_blank = 1'b1;
      end
    endcase
  end

  always_comb begin
    seg = 7'b0000000;
    if (!w_blank) begin
      case (w_nib)
        4'd0:    seg = 7'b0111111;
        4'd1:    seg = 7'b0000110;
        4'd2:    seg = 7'b1011011;
        4'd3:    seg = 7'b1001111;
        4'd4:    seg = 7'b1100110;
        4'd5:    seg = 7'b1101101;
        4'd6:    seg = 7'b1111101;
        4'd7:    seg = 7'b0000111;
        4'd8:    seg = 7'b1111111;
        4'd9:    seg = 7'b1101111;
        default: seg = 7'b0000000;
      endcase
    end
  end

  assign out_reg   = r_out;
  assign busy      = (r_state == StConvert);
  assign digit_sel = r_digit_sel;

endmodule
